// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter merging N AXI-stream byte sources onto one registered UART TX stream.
// Optional CTS flow control is compiled in with `define UART_TX_ARB_CTS_EN.
module uart_tx_arbiter #(
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*8-1:0] s_axis_tdata,
    input  logic [N-1:0]   s_axis_tvalid,
    output logic [N-1:0]   s_axis_tready,
    input  logic [N-1:0]   s_axis_tlast,
    output logic [7:0]     m_axis_tdata,
    output logic           m_axis_tvalid,
    input  logic           m_axis_tready,
    input  logic           uart_cts,
    output logic [N-1:0]   grant,
    output logic           busy
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, PASS} state_t;

    state_t       state;
    logic [W-1:0] sel;
    logic [W-1:0] last;
    logic [W-1:0] cand;
    logic [W-1:0] pick;
    logic         found;
    logic         cts_ok;
    logic         take_ok;
    logic         xfer;
    logic [7:0]   in_data;
    logic         in_last;

`ifdef UART_TX_ARB_CTS_EN
    assign cts_ok = !uart_cts;
`else
    logic unused_cts;
    assign unused_cts = uart_cts;
    assign cts_ok     = 1'b1;
`endif

    // Modulo-N step so non-power-of-two N wraps from N-1 back to 0.
    function automatic logic [W-1:0] wrap_idx(input logic [W-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % N;
        return W'(s);
    endfunction

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = wrap_idx(last, k);
            if (!found && s_axis_tvalid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Accept only when the output register is empty or draining this cycle.
    assign take_ok = (state == PASS) && cts_ok && (!m_axis_tvalid || m_axis_tready);
    assign xfer    = take_ok && s_axis_tvalid[sel];
    assign in_data = s_axis_tdata[8*sel +: 8];
    assign in_last = s_axis_tlast[sel];
    assign busy    = (state == PASS) || m_axis_tvalid;

    always_comb begin
        s_axis_tready = '0;
        if (take_ok) s_axis_tready[sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant         <= '0;
            sel           <= '0;
            last          <= W'(N - 1);
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 8'h00;
        end else begin
            if (xfer) begin
                m_axis_tdata  <= in_data;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        grant       <= '0;
                        grant[pick] <= 1'b1;
                        sel         <= pick;
                        state       <= PASS;
                    end
                end
                PASS: begin
                    if (xfer && in_last) begin
                        last  <= sel;
                        grant <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: N=2 instance for data-path tests, N=3 instance for wrap.
// Expected output bytes are queued at stimulus time and compared on every output handshake.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] s_data;
    logic [1:0]  s_valid, s_ready, s_last;
    logic [7:0]  m_data;
    logic        m_valid, m_ready, cts;
    logic [1:0]  grant;
    logic        busy;

    logic [23:0] s3_data;
    logic [2:0]  s3_valid, s3_ready, s3_last;
    logic [7:0]  m3_data;
    logic        m3_valid, m3_ready, cts3;
    logic [2:0]  grant3;
    logic        busy3;

    uart_tx_arbiter #(.N(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tlast(s_last),
        .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
        .uart_cts(cts), .grant(grant), .busy(busy)
    );

    uart_tx_arbiter #(.N(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s3_data), .s_axis_tvalid(s3_valid), .s_axis_tready(s3_ready), .s_axis_tlast(s3_last),
        .m_axis_tdata(m3_data), .m_axis_tvalid(m3_valid), .m_axis_tready(m3_ready),
        .uart_cts(cts3), .grant(grant3), .busy(busy3)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [8:0] src0_q[$];
    logic [8:0] src1_q[$];
    int         acc0 = 0;
    int         sink_mode = 0;
    bit         toggle_ph = 1'b0;
    logic       ready_smp0 = 1'b0;
    bit         stalled = 1'b0;
    logic [7:0] stall_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample just before posedge, retire beats after the edge.
    task automatic tick();
        logic fire0, fire1;
        s_valid[0]  = src0_q.size() != 0;
        s_data[7:0] = s_valid[0] ? src0_q[0][7:0] : 8'h00;
        s_last[0]   = s_valid[0] ? src0_q[0][8] : 1'b0;
        s_valid[1]  = src1_q.size() != 0;
        s_data[15:8] = s_valid[1] ? src1_q[0][7:0] : 8'h00;
        s_last[1]   = s_valid[1] ? src1_q[0][8] : 1'b0;
        toggle_ph   = !toggle_ph;
        m_ready     = (sink_mode == 0) ? 1'b1 : toggle_ph;
        #4;
        ready_smp0 = s_ready[0];
        fire0 = s_valid[0] && s_ready[0];
        fire1 = s_valid[1] && s_ready[1];
        if (stalled) begin
            check("valid_hold", m_valid, 1'b1);
            check("data_stable", m_data, stall_data);
        end
        if (m_valid && m_ready) begin
            check("out_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("m_data", m_data, exp_q.pop_front());
        end
        stalled    = m_valid && !m_ready;
        stall_data = m_data;
        @(negedge clk);
        if (fire0) begin
            src0_q.delete(0);
            acc0++;
        end
        if (fire1) src1_q.delete(0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src0_q.size() != 0 || src1_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_budget", n < budget, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        src0_q.delete();
        src1_q.delete();
        stalled = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        s_data = '0; s_valid = '0; s_last = '0; m_ready = 1'b1; cts = 1'b0;
        s3_data = '0; s3_valid = '0; s3_last = '0; m3_ready = 1'b1; cts3 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_s_ready", s_ready, 2'b00);
        check("rst_grant3", grant3, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single source, sink always ready.
        src0_q.push_back({1'b0, 8'h48});
        src0_q.push_back({1'b1, 8'h69});
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h69);
        tick();
        check("t1_idle_no_ready", ready_smp0, 1'b0);
        check("t1_grant", grant, 2'b01);
        check("t1_busy", busy, 1'b1);
        tick();
        check("t1_first_ready", ready_smp0, 1'b1);
        check("t1_grant_hold", grant, 2'b01);
        tick();
        check("t1_grant_released", grant, 2'b00);
        check("t1_busy_out_full", busy, 1'b1);
        tick();
        check("t1_busy_drop", busy, 1'b0);
        check("t1_all_out", exp_q.size(), 0);

        // Contention: both sources valid, round-robin per packet.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 3; b++) begin
                src0_q.push_back({b == 2, 8'hA0 + 8'(b)});
                src1_q.push_back({b == 2, 8'hB0 + 8'(b)});
            end
            for (int b = 0; b < 3; b++) exp_q.push_back(8'hA0 + 8'(b));
            for (int b = 0; b < 3; b++) exp_q.push_back(8'hB0 + 8'(b));
        end
        drain(100);

        // Backpressure: sink ready toggles every cycle.
        sink_mode = 1;
        for (int b = 1; b <= 4; b++) begin
            src0_q.push_back({b == 4, 8'(b)});
            exp_q.push_back(8'(b));
        end
        drain(100);
        sink_mode = 0;

        // CTS gating.
        acc0 = 0;
        for (int b = 0; b < 4; b++) begin
            src0_q.push_back({b == 3, 8'h10 + 8'(b)});
            exp_q.push_back(8'h10 + 8'(b));
        end
`ifdef UART_TX_ARB_CTS_EN
        n = 0;
        while (acc0 < 2 && n < 50) begin
            tick();
            n++;
        end
        check("t4_two_accepted", acc0, 2);
        cts = 1'b1;
        tick();
        check("t4_cts_blocks_now", ready_smp0, 1'b0);
        tick();
        tick();
        check("t4_cts_hold", acc0, 2);
        check("t4_byte11_drained", exp_q.size(), 2);
        cts = 1'b0;
        tick();
        check("t4_cts_resume", ready_smp0, 1'b1);
        drain(50);
        check("t4_all_accepted", acc0, 4);
`else
        cts = 1'b1;
        tick();
        tick();
        check("t4_cts_ignored", ready_smp0, 1'b1);
        drain(50);
        check("t4_all_accepted", acc0, 4);
        cts = 1'b0;
`endif

        // Asynchronous reset in the middle of a packet.
        acc0 = 0;
        src0_q.push_back({1'b0, 8'h55});
        src0_q.push_back({1'b0, 8'h56});
        src0_q.push_back({1'b1, 8'h57});
        n = 0;
        while (acc0 < 1 && n < 50) begin
            tick();
            n++;
        end
        check("t5_pre_valid", m_valid, 1'b1);
        check("t5_pre_data", m_data, 8'h55);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_m_valid", m_valid, 1'b0);
        check("t5_rst_m_data", m_data, 8'h00);
        check("t5_rst_grant", grant, 2'b00);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_s_ready", s_ready, 2'b00);
        exp_q.delete();
        src0_q.delete();
        src1_q.delete();
        stalled = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        src1_q.push_back({1'b1, 8'hB9});
        src0_q.push_back({1'b1, 8'hA9});
        exp_q.push_back(8'hA9);
        exp_q.push_back(8'hB9);
        tick();
        check("t5_req0_first", grant, 2'b01);
        drain(50);

        // Wrap with N=3: requester 2 then requester 0.
        do_reset();
        s3_data  = {8'hC2, 8'h00, 8'hC0};
        s3_last  = 3'b101;
        s3_valid = 3'b100;
        @(negedge clk);
        check("t6_grant_req2", grant3, 3'b100);
        @(negedge clk);
        check("t6_grant2_released", grant3, 3'b000);
        check("t6_m3_valid", m3_valid, 1'b1);
        check("t6_m3_data_c2", m3_data, 8'hC2);
        s3_valid = 3'b101;
        @(negedge clk);
        check("t6_wrap_req0", grant3, 3'b001);
        @(negedge clk);
        check("t6_m3_data_c0", m3_data, 8'hC0);
        check("t6_grant0_released", grant3, 3'b000);
        s3_valid = 3'b000;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit byte stream between N independent AXI-stream byte sources (e.g. command-response path and button/switch event reporter) inside the UART example core. Arbitrates round-robin at packet granularity (holds grant until `tlast`), registers the output byte toward the `uart_tx` instance, and throttles acceptance on the peer's CTS line so the host is never overrun by more than one character.

## Interface
- `N`, 2: number of requesters, 2..8.
- `clk`  in  1  core clock (125 MHz in the example design).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_axis_tdata`  in  N*8  byte from requester i in bits [8*i+7:8*i].
- `s_axis_tvalid`  in  N  per-requester valid.
- `s_axis_tready`  out  N  per-requester ready; at most one bit set.
- `s_axis_tlast`  in  N  per-requester end of packet.
- `m_axis_tdata`  out  8  byte to UART transmitter.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  UART transmitter ready.
- `uart_cts`  in  1  peer clear-to-send, already synchronized to `clk`, active-low (0 = peer may receive).
- `grant`  out  N  one-hot current grant, 0 when idle.
- `busy`  out  1  high while a packet is granted or the output register is full.

## Operation
- State machine, two states: IDLE, PASS.
- IDLE: if any `s_axis_tvalid` set, pick first set index searching from `last+1` upward, wrapping modulo N; register `grant`, `sel <= index`, go PASS. No `tready` asserted in IDLE.
- PASS: `s_axis_tready[sel] = cts_ok && (!m_axis_tvalid || m_axis_tready)`; all other ready bits 0.
- Input transfer (`tvalid && tready` on `sel`): load byte into output register, set `m_axis_tvalid`. If `tlast` set on that beat: `last <= sel`, `grant <= 0`, go IDLE.
- Output register: `m_axis_tvalid` clears on `m_axis_tready` unless reloaded same cycle (simultaneous drain and load keeps valid high, new data). `m_axis_tvalid` never drops without handshake; `m_axis_tdata` stable while valid and not ready.
- `cts_ok` = `!uart_cts` when feature enabled (see Configuration), else 1. CTS only blocks input acceptance; byte already in output register is still delivered.
- Requester dropping `tvalid` mid-packet does not release grant; grant released only by `tlast`.
- `busy = (state == PASS) || m_axis_tvalid`.
- `last` is a $clog2(N)-bit index; wrap from N-1 to 0; search uses modulo-N arithmetic, not power-of-two wrap.

## Timing
- Reset (async assert, sync-released by upstream reset logic): state IDLE, `grant` 0, `last` N-1 (so requester 0 wins first), `m_axis_tvalid` 0, `m_axis_tdata` 0, all `s_axis_tready` 0, `busy` 0. Reset mid-packet discards the output byte and any partial packet.
- Arbitration latency: `tvalid` seen in IDLE at cycle t -> `grant` at t+1, first `tready` possible at t+1.
- Data latency: input accepted at cycle t -> `m_axis_tvalid` at t+1.
- Throughput: one byte/cycle within a packet when `m_axis_tready` held high; one idle cycle between packets (IDLE state).
- CTS: `uart_cts` going 1 at cycle t -> `tready` 0 at cycle t (combinational from synchronized input); resumes same cycle CTS returns to 0.

## Configuration
- `UART_TX_ARB_CTS_EN`: defined -> acceptance gated by `uart_cts` as above. Undefined -> `cts_ok` tied 1, `uart_cts` ignored (port kept, unused).

## Test plan
- Single source: N=2, requester 0 sends 0x48,0x69(tlast) with sink always ready -> `grant`=01 at t+1, m_axis emits 0x48,0x69 back-to-back, `grant` 0 after last beat, `busy` drops one cycle after final output handshake.
- Contention/round-robin: both requesters valid continuously with 3-byte packets (0xA0.. and 0xB0..) -> output order A0,A1,A2,B0,B1,B2,A0..., never interleaved within a packet.
- Backpressure: sink `tready` toggled 1/0 each cycle during 4-byte packet 0x01..0x04 -> all four bytes delivered in order, `m_axis_tdata` stable while stalled, no byte duplicated or lost.
- CTS (macro defined): `uart_cts`=1 after second byte of 0x10..0x13 -> `s_axis_tready` 0 immediately, byte 0x11 still drains, 0x12 accepted only after `uart_cts`=0; macro undefined -> CTS toggling has no effect.
- Async reset mid-packet: assert `rst_n`=0 after 0x55 accepted, before tlast -> all outputs to reset values without a clock edge; after release requester 0 wins first arbitration.
- Wrap: N=3, only requesters 2 then 0 valid -> grant order 100 then 001, `last` wraps 2 -> 0.
